// File: rtl/down_counter_reload.sv
// down_counter_reload: loadable down counter with one-shot/periodic reload and terminal-count pulse
module down_counter_reload #(
    parameter int bits = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            load,
    input  logic [bits-1:0] load_val,
    input  logic            mode,
    output logic [bits-1:0] Q,
    output logic            tc,
    output logic            busy,
    output logic            done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_n;
    logic [bits-1:0] reload_reg, reload_n, q_n;
    logic            mode_reg, mode_n, tc_n;

    // next-state logic: load beats counting; only RUN reacts to en, so Q never wraps below 0
    always_comb begin
        state_n  = state;
        q_n      = Q;
        tc_n     = 1'b0;
        reload_n = reload_reg;
        mode_n   = mode_reg;
        if (load) begin
            q_n      = load_val;
            reload_n = load_val;
            mode_n   = mode;
            state_n  = (load_val != '0) ? RUN : IDLE;
        end else if (state == RUN && en) begin
            if (Q == bits'(1)) begin
                tc_n    = 1'b1;
                q_n     = mode_reg ? reload_reg : '0;
                state_n = mode_reg ? RUN : DONE;
            end else begin
                q_n = Q - bits'(1);
            end
        end
    end

    // state and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            Q          <= '0;
            tc         <= 1'b0;
            reload_reg <= '0;
            mode_reg   <= 1'b0;
        end else begin
            state      <= state_n;
            Q          <= q_n;
            tc         <= tc_n;
            reload_reg <= reload_n;
            mode_reg   <= mode_n;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
endmodule

// File: tb/tb_down_counter_reload.sv
// tb_down_counter_reload: table vectors, directed corner sequences and random stimulus against a reference model
module tb_down_counter_reload;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         mode = 1'b0;
    logic [W-1:0] Q;
    logic         tc, busy, done;

    int tests = 0;
    int fails = 0;

    // reference model: loaded value, periodic flag, count of enabled cycles since load
    int mv = 0;
    int me = 0;
    bit mper = 0;
    bit mtc = 0;

    typedef struct {
        logic r, l, e;
        logic [W-1:0] lv;
        logic md;
        logic [W-1:0] q;
        logic t, b, d;
    } vec_t;
    vec_t vecs[$];

    down_counter_reload #(.bits(W)) dut (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
        .mode(mode), .Q(Q), .tc(tc), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic bit m_busy();
        return mv != 0 && (mper || me < mv);
    endfunction

    function automatic logic [W+2:0] m_exp();
        int q;
        q = (mv == 0) ? 0 : mper ? mv - (me % mv) : mv - me;
        return {W'(q), mtc, m_busy(), mv != 0 && !mper && me == mv};
    endfunction

    task automatic model(input logic r, l, e, input logic [W-1:0] lv, input logic md);
        mtc = 0;
        if (r) begin
            mv = 0; me = 0; mper = 0;
        end else if (l) begin
            mv = int'(lv); me = 0; mper = md;
        end else if (e && m_busy()) begin
            me++;
            mtc = (me % mv) == 0;
        end
    endtask

    task automatic step(input logic r, l, e, input logic [W-1:0] lv, input logic md);
        logic [W+2:0] act, exp;
        reset = r; load = l; en = e; load_val = lv; mode = md;
        @(posedge clk);
        #1;
        model(r, l, e, lv, md);
        exp = m_exp();
        act = {Q, tc, busy, done};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL model t=%0t {Q,tc,busy,done} got %h/%b%b%b want %h/%b%b%b", $time,
                     act[W+2:3], act[2], act[1], act[0], exp[W+2:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic chk(input string name, input logic [W+2:0] act, input logic [W+2:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s {Q,tc,busy,done} got %h/%b%b%b want %h/%b%b%b", name,
                     act[W+2:3], act[2], act[1], act[0], exp[W+2:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic add(input logic r, l, e, input logic [W-1:0] lv, input logic md,
                       input logic [W-1:0] q, input logic t, b, d);
        vecs.push_back('{r, l, e, lv, md, q, t, b, d});
    endtask

    initial begin
        add(1,0,0, 0,0,  0,0,0,0);
        add(1,1,1, 7,1,  0,0,0,0);
        add(0,1,1, 3,0,  3,0,1,0);
        add(0,0,1, 0,0,  2,0,1,0);
        add(0,0,1, 0,0,  1,0,1,0);
        add(0,0,1, 0,0,  0,1,0,1);
        add(0,0,1, 0,0,  0,0,0,1);
        add(0,1,1, 0,1,  0,0,0,0);
        add(0,0,1, 0,0,  0,0,0,0);
        add(0,1,0, 2,1,  2,0,1,0);
        add(0,0,0, 0,0,  2,0,1,0);
        add(0,0,1, 0,0,  1,0,1,0);
        add(0,0,1, 0,0,  2,1,1,0);
        add(0,0,1, 0,0,  1,0,1,0);
        add(0,0,1, 0,0,  2,1,1,0);
        add(0,1,1, 1,1,  1,0,1,0);
        add(0,0,1, 0,0,  1,1,1,0);
        add(0,0,1, 0,0,  1,1,1,0);
        add(0,1,1, 6,1,  6,0,1,0);
        add(0,0,1, 0,0,  5,0,1,0);
        add(0,0,1, 0,0,  4,0,1,0);
        add(0,0,1, 0,0,  3,0,1,0);
        add(0,0,1, 0,0,  2,0,1,0);
        add(0,0,1, 0,0,  1,0,1,0);
        add(0,1,1, 2,1,  2,0,1,0);
        add(0,0,1, 0,0,  1,0,1,0);
        add(0,0,1, 0,0,  2,1,1,0);
        add(1,1,1, 9,0,  0,0,0,0);
        add(0,0,1, 0,0,  0,0,0,0);
        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].l, vecs[i].e, vecs[i].lv, vecs[i].md);
            chk($sformatf("vec%0d", i), {Q, tc, busy, done},
                {vecs[i].q, vecs[i].t, vecs[i].b, vecs[i].d});
        end
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
        step(0, 1, 1, 3, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 1);
        chk("oneshot_end", {Q, tc, busy, done}, {W'(0), 1'b1, 1'b0, 1'b1});
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 1);
        chk("oneshot_hold", {Q, tc, busy, done}, {W'(0), 1'b0, 1'b0, 1'b1});
        step(0, 1, 1, 4, 1);
        for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 0);
        chk("periodic4", {Q, tc, busy, done}, {W'(4), 1'b1, 1'b1, 1'b0});
        step(0, 1, 1, 5, 0);
        for (int i = 0; i < 16; i++) step(0, 0, (i % 4 == 0) || (i % 4 == 3), 0, 0);
        chk("en_toggle", {Q, tc, busy, done}, {W'(0), 1'b0, 1'b0, 1'b1});
        step(0, 1, 0, 15, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0);
        chk("at9", {Q, tc, busy, done}, {W'(9), 1'b0, 1'b1, 1'b0});
        step(1, 0, 1, 0, 0);
        chk("reset_mid", {Q, tc, busy, done}, {W'(0), 1'b0, 1'b0, 1'b0});
        step(0, 0, 1, 0, 0);
        chk("post_reset", {Q, tc, busy, done}, {W'(0), 1'b0, 1'b0, 1'b0});
        step(0, 1, 1, 15, 0);
        for (int i = 0; i < 14; i++) step(0, 0, 1, 0, 0);
        chk("full_14", {Q, tc, busy, done}, {W'(1), 1'b0, 1'b1, 1'b0});
        step(0, 0, 1, 0, 0);
        chk("full_15", {Q, tc, busy, done}, {W'(0), 1'b1, 1'b0, 1'b1});
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 9) < 7,
                 W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/down_counter_reload.md
DOWN_COUNTER_RELOAD -- requirements
Module: down_counter_reload

Interface
REQ-001 Parameter: bits, default 4, width of count, load value and reload register.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset; sampled on rising clk only.
REQ-004 Port: en  input  1  count enable; when low, count and state hold.
REQ-005 Port: load  input  1  load strobe; captures load_val and mode.
REQ-006 Port: load_val  input  bits  start/reload value.
REQ-007 Port: mode  input  1  0 = one-shot, 1 = periodic; sampled only when load=1.
REQ-008 Port: Q  output  bits  current count, registered.
REQ-009 Port: tc  output  1  terminal-count pulse, registered, one clk wide.
REQ-010 Port: busy  output  1  high while state is RUN.
REQ-011 Port: done  output  1  sticky one-shot completion flag, high while state is DONE.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, RUN, DONE; busy = (state==RUN), done = (state==DONE).
REQ-013 The block SHALL hold internal registers reload_reg (bits wide) and mode_reg (1 bit), both written only on load.
REQ-014 Priority per edge SHALL be: reset > load > en-driven counting > hold.
REQ-015 Load, any state, load_val != 0: Q <= load_val, reload_reg <= load_val, mode_reg <= mode, state <= RUN, tc <= 0.
REQ-016 Load, any state, load_val == 0: Q <= 0, reload_reg <= 0, mode_reg <= mode, state <= IDLE, tc <= 0; no tc pulse ever results.
REQ-017 RUN, en=1, Q > 1: Q <= Q - 1, tc <= 0.
REQ-018 RUN, en=1, Q == 1, mode_reg=0: Q <= 0, state <= DONE, tc <= 1 for exactly the next cycle.
REQ-019 RUN, en=1, Q == 1, mode_reg=1: Q <= reload_reg, state stays RUN, tc <= 1 for exactly the next cycle; period = reload_reg enabled cycles.
REQ-020 RUN, en=0: Q and state hold; tc <= 0.
REQ-021 IDLE or DONE without load: Q holds (0), tc <= 0, en ignored; no wrap below 0 ever occurs.
REQ-022 load coincident with the Q==1 terminal edge: load wins, no tc pulse, new value loaded.
REQ-023 load_val == 1 in periodic mode: tc SHALL pulse every enabled cycle (Q reloads to 1 each time).
REQ-024 Changes to mode while not loading SHALL have no effect.
REQ-025 Decrement SHALL be unsigned modulo-2^bits arithmetic on bits-wide values; load_val = 2^bits-1 SHALL count the full range.

Reset
REQ-026 reset=1 at a rising edge SHALL force Q=0, tc=0, state=IDLE (busy=0, done=0), reload_reg=0, mode_reg=0, regardless of load/en.
REQ-027 Reset asserted mid-RUN SHALL abort the count with no tc pulse; outputs change only at the clk edge (no asynchronous effect).
REQ-028 After reset release the block SHALL remain IDLE until a load with nonzero load_val.

Verification (bits=4)
REQ-029 Reset 5 cycles then load_val=3, mode=0, en=1 -> Q: 3,2,1,0; tc high one cycle coincident with Q=0; done=1 and busy=0 thereafter; Q stays 0 for 10 more cycles.
REQ-030 load_val=4, mode=1, en=1 for 12 cycles -> Q: 4,3,2,1,4,3,2,1,4,...; tc high on each cycle Q shows 4 after a reload (every 4th cycle); busy stays 1.
REQ-031 load_val=5, en toggled 1,0,0,1,... -> Q holds during en=0 cycles; tc fires only after 5 enabled cycles.
REQ-032 Periodic with load_val=6, assert load with load_val=2 on the cycle Q==1 -> no tc that cycle; Q=2 next, then 1, then reload to 2 with tc.
REQ-033 reset asserted while Q=9 in RUN -> next edge Q=0, busy=0, done=0, tc=0; subsequent en=1 keeps Q=0.
REQ-034 load_val=0 with mode=1 -> Q=0, state IDLE, tc never asserts; load_val=15, mode=0 -> 15 enabled cycles to tc.
